// File: rtl/gate_op_arbiter.sv
// Round-robin front end for one shared, registered bitwise logic unit.
// Each accepted request runs IDLE -> EXEC -> RESP and returns a tagged result.
module gate_op_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int ID_W  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [2*N_REQ-1:0]     op_sel,
    input  logic [WIDTH*N_REQ-1:0] op_a,
    input  logic [WIDTH*N_REQ-1:0] op_b,
    output logic [N_REQ-1:0]       gnt,
    output logic                   busy,
    output logic                   res_valid,
    output logic [WIDTH-1:0]       res_data,
    output logic [ID_W-1:0]        res_id
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]   win_q, win_d;
    logic [1:0]        opc_q, opc_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic              busy_q, busy_d;
    logic              res_valid_q, res_valid_d;
    logic [WIDTH-1:0]  res_data_q, res_data_d;
    logic [ID_W-1:0]   res_id_q, res_id_d;

    logic [ID_W-1:0]   pick;
    logic              found;
    int                idx;

    function automatic logic [WIDTH-1:0] alu(input logic [1:0] o,
                                             input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
        case (o)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    // First requester at or above rr_ptr, wrapping back to 0.
    always_comb begin
        pick  = rr_ptr_q;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % N_REQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = ID_W'(idx);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        win_d       = win_q;
        opc_d       = opc_q;
        a_d         = a_q;
        b_d         = b_q;
        gnt_d       = gnt_q;
        busy_d      = busy_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_id_d    = res_id_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = EXEC;
                    win_d   = pick;
                    opc_d   = op_sel[2*pick +: 2];
                    a_d     = op_a[WIDTH*pick +: WIDTH];
                    b_d     = op_b[WIDTH*pick +: WIDTH];
                    gnt_d   = N_REQ'(1) << pick;
                    busy_d  = 1'b1;
                end
            end
            EXEC: begin
                state_d     = RESP;
                gnt_d       = '0;
                res_valid_d = 1'b1;
                res_data_d  = alu(opc_q, a_q, b_q);
                res_id_d    = win_q;
            end
            RESP: begin
                state_d     = IDLE;
                res_valid_d = 1'b0;
                busy_d      = 1'b0;
                rr_ptr_d    = (win_q == ID_W'(N_REQ - 1)) ? '0 : win_q + ID_W'(1);
            end
            default: begin
                state_d     = IDLE;
                gnt_d       = '0;
                busy_d      = 1'b0;
                res_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            win_q       <= '0;
            opc_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            gnt_q       <= '0;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            win_q       <= win_d;
            opc_q       <= opc_d;
            a_q         <= a_d;
            b_q         <= b_d;
            gnt_q       <= gnt_d;
            busy_q      <= busy_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_id_q    <= res_id_d;
        end
    end

    assign gnt       = gnt_q;
    assign busy      = busy_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;

endmodule

// File: tb/tb_gate_op_arbiter.sv
// Bench for gate_op_arbiter: directed vector table, multi-cycle sequences and
// random traffic, all checked against a transaction-timeline reference model.
module tb_gate_op_arbiter;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int IW = 2;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [N-1:0]        req;
    logic [N-1:0][1:0]   opv;
    logic [N-1:0][W-1:0] av, bv;
    logic [N-1:0]        gnt;
    logic                busy, res_valid;
    logic [W-1:0]        res_data;
    logic [IW-1:0]       res_id;

    always #5 clk = ~clk;

    gate_op_arbiter #(.N_REQ(N), .WIDTH(W), .ID_W(IW)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .op_sel(opv), .op_a(av), .op_b(bv),
        .gnt(gnt), .busy(busy), .res_valid(res_valid), .res_data(res_data), .res_id(res_id)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: an accepted request at edge n owns cycles n (grant) and
    // n+1 (result); the next arbitration is allowed at edge n+3.
    function automatic int pick_rr(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++)
            if (r[(p + k) % N]) return (p + k) % N;
        return 0;
    endfunction

    function automatic logic [W-1:0] gate_fn(input logic [1:0] o, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        case (o)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    int         cyc_n, ev_n, rr, win, m_id, mp;
    logic [W-1:0] m_res, m_data;

    always_comb mp = pick_rr(req, rr);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_n <= 0; ev_n <= -10; rr <= 0; win <= 0;
            m_res <= '0; m_data <= '0; m_id <= 0;
        end else begin
            cyc_n <= cyc_n + 1;
            if (req != '0 && cyc_n + 1 >= ev_n + 3) begin
                ev_n  <= cyc_n + 1;
                win   <= mp;
                m_res <= gate_fn(opv[mp], av[mp], bv[mp]);
                rr    <= (mp + 1) % N;
            end
            if (cyc_n + 1 == ev_n + 1) begin
                m_data <= m_res;
                m_id   <= win;
            end
        end
    end

    task automatic tick();
        logic [N-1:0] eg;
        @(negedge clk);
        eg = (rst_n && cyc_n == ev_n) ? (N'(1) << win) : '0;
        chk("model_gnt", 32'(gnt), 32'(eg));
        chk("model_busy", 32'(busy), 32'(rst_n && (cyc_n == ev_n || cyc_n == ev_n + 1)));
        chk("model_rv", 32'(res_valid), 32'(rst_n && cyc_n == ev_n + 1));
        chk("model_data", 32'(res_data), 32'(m_data));
        chk("model_id", 32'(res_id), 32'(m_id));
    endtask

    // Single transaction; operand A of the owner is swapped to new_a once granted.
    task automatic run_one(input int id, input logic [1:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] new_a,
                           input logic [W-1:0] exp_d);
        opv[id] = op; av[id] = a; bv[id] = b;
        req = N'(1) << id;
        tick();
        chk("vec_gnt", 32'(gnt), 32'(N'(1) << id));
        chk("vec_busy_exec", 32'(busy), 1);
        req = '0; av[id] = new_a;
        tick();
        chk("vec_rv", 32'(res_valid), 1);
        chk("vec_data", 32'(res_data), 32'(exp_d));
        chk("vec_id", 32'(res_id), 32'(id));
        chk("vec_gnt_off", 32'(gnt), 0);
        tick();
        chk("vec_rv_off", 32'(res_valid), 0);
        chk("vec_busy_off", 32'(busy), 0);
        chk("vec_data_hold", 32'(res_data), 32'(exp_d));
    endtask

    typedef struct {
        int id; logic [1:0] op; logic [W-1:0] a, b, ed;
    } vec_t;

    vec_t vt[6];
    int   g_seen[$];
    int   last_g, last_rv;

    initial begin
        vt[0] = '{0, 2'd1, 8'hA0, 8'h0C, 8'hAC};
        vt[1] = '{2, 2'd0, 8'hF0, 8'h3C, 8'h30};
        vt[2] = '{2, 2'd1, 8'hF0, 8'h3C, 8'hFC};
        vt[3] = '{2, 2'd2, 8'hF0, 8'h3C, 8'hCC};
        vt[4] = '{2, 2'd3, 8'hF0, 8'h3C, 8'h03};
        vt[5] = '{3, 2'd0, 8'hFF, 8'h0F, 8'h0F};

        rst_n = 1'b0; req = '0; opv = '0; av = '0; bv = '0;
        repeat (2) tick();
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rv", 32'(res_valid), 0);
        chk("rst_data", 32'(res_data), 0);
        rst_n = 1'b1;
        tick();

        // Vector table: single request, all opcodes, then serve 3 so rr_ptr wraps to 0.
        foreach (vt[i]) run_one(vt[i].id, vt[i].op, vt[i].a, vt[i].b, ~vt[i].a, vt[i].ed);

        // Fairness with all four requesting.
        for (int i = 0; i < N; i++) begin
            opv[i] = 2'(i); av[i] = W'(8'h10 * (i + 1)); bv[i] = W'(8'h5A + i);
        end
        req = '1; last_g = -1; last_rv = -1;
        for (int t = 1; t <= 18; t++) begin
            tick();
            if (gnt != '0) begin
                for (int i = 0; i < N; i++) if (gnt[i]) last_g = i;
                g_seen.push_back(last_g);
            end
            if (res_valid) begin
                chk("fair_id", 32'(res_id), 32'(last_g));
                if (last_rv >= 0) chk("fair_spacing", 32'(t - last_rv), 3);
                last_rv = t;
            end
            if (t == 16) req = '0;
        end
        chk("fair_count", 32'(g_seen.size()), 6);
        for (int i = 0; i < 6 && i < g_seen.size(); i++)
            chk("fair_order", 32'(g_seen[i]), 32'(i % N));

        // Wrap and skip after serving requester 3.
        run_one(3, 2'd2, 8'h0F, 8'hFF, 8'h00, 8'hF0);
        g_seen.delete();
        req = 4'b0110;
        for (int t = 1; t <= 7; t++) begin
            tick();
            if (gnt != '0) g_seen.push_back(gnt[1] ? 1 : gnt[2] ? 2 : gnt[0] ? 0 : 3);
            chk("skip_no_gnt0", 32'(gnt[0]), 0);
            if (t == 4) req = '0;
        end
        chk("skip_count", 32'(g_seen.size()), 2);
        if (g_seen.size() == 2) begin
            chk("skip_first", 32'(g_seen[0]), 1);
            chk("skip_second", 32'(g_seen[1]), 2);
        end

        // Operand change after grant must not leak into the result.
        run_one(1, 2'd1, 8'h11, 8'h00, 8'hFF, 8'h11);

        // Reset during EXEC of requester 3 (rr_ptr would otherwise stay at 3).
        run_one(2, 2'd0, 8'hFF, 8'h55, 8'h00, 8'h55);
        opv[3] = 2'd1; av[3] = 8'h01; bv[3] = 8'h02;
        req = 4'b1000;
        tick();
        chk("abort_gnt_pre", 32'(gnt), 32'(4'b1000));
        #2 rst_n = 1'b0;
        #1;
        chk("abort_gnt", 32'(gnt), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_rv", 32'(res_valid), 0);
        req = '0;
        tick();
        rst_n = 1'b1;
        for (int t = 0; t < 3; t++) begin
            tick();
            chk("abort_no_rv", 32'(res_valid), 0);
        end
        req = '1;
        tick();
        chk("abort_rr0", 32'(gnt), 32'(4'b0001));
        req = '0;
        repeat (3) tick();

        // Random traffic against the model.
        for (int t = 0; t < 600; t++) begin
            req = N'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) req = '0;
            for (int i = 0; i < N; i++) begin
                opv[i] = 2'($urandom);
                av[i]  = W'($urandom);
                bv[i]  = W'($urandom);
            end
            tick();
        end
        req = '0;
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/gate_op_arbiter.md
Name: gate_op_arbiter

Overview:
- Shares one registered bitwise logic unit between N_REQ requesters, using round-robin arbitration.
- The unit supports OR, AND, XOR and NOR.
- Each requester presents an opcode and two operands. The block grants one requester, latches its inputs, executes once, and returns a tagged result.
- It sits between the gate-level datapath and client blocks, so the team instantiates only one logic unit instead of one per client.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 8, operand and result width in bits.
- ID_W, 2, requester-id width; must equal clog2(N_REQ).

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- req  input  N_REQ  request bit per requester.
- op_sel  input  2*N_REQ  opcode per requester; requester i uses bits [2i+1:2i].
- op_a  input  WIDTH*N_REQ  operand A per requester; requester i uses bits [WIDTH*i+WIDTH-1:WIDTH*i].
- op_b  input  WIDTH*N_REQ  operand B per requester; same slicing as op_a.
- gnt  output  N_REQ  one-hot grant, registered.
- busy  output  1  high whenever state is not IDLE.
- res_valid  output  1  one-cycle result strobe.
- res_data  output  WIDTH  result value.
- res_id  output  ID_W  index of the requester that owns res_data.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. While rst_n=0, the following hold:
  - state=IDLE, rr_ptr=0.
  - gnt=0, busy=0, res_valid=0, res_data=0, res_id=0.
  - All latched operand and opcode registers are 0.
- Opcodes: 00 = a&b, 01 = a|b, 10 = a^b, 11 = ~(a|b). The result is exactly WIDTH bits; there is no carry and no extension.
- State machine: IDLE -> EXEC -> RESP -> IDLE.
  - IDLE: if any req bit is 1 at a rising edge, select the winner and capture op_sel, op_a and op_b of the winner into internal registers. Set gnt[winner]=1 and go to EXEC. If req=0, remain in IDLE with all outputs idle.
  - EXEC, 1 cycle: gnt is one-hot for this cycle only. At the closing edge, register the result into res_data, set res_id=winner, res_valid=1, gnt=0, and go to RESP.
  - RESP, 1 cycle: res_valid=1. At the closing edge, set res_valid=0, rr_ptr=(winner+1) mod N_REQ, and go to IDLE.
- Arbitration: the winner is the first asserted req bit found when searching from index rr_ptr upward, wrapping from N_REQ-1 to 0. If all bits are requesting, grants rotate 0,1,2,...,N_REQ-1,0.
- Latency: with req sampled at edge T, gnt is high in cycle T..T+1 and res_valid is high in cycle T+1..T+2. A new arbitration happens at the earliest at edge T+3. Peak throughput is 1 operation per 3 cycles.
- Handshake:
  - A requester holds req, op_sel, op_a and op_b stable until it sees its gnt bit.
  - Operands are latched at arbitration, so changes afterwards do not affect the result.
  - A requester that keeps req high through RESP is treated as a new request. Under round-robin it loses to any other requester.
- req deasserted during EXEC or RESP: no effect; the operation completes normally.
- Outputs hold between operations: res_data and res_id keep their last values after res_valid drops.
- Reset mid-operation: the operation is aborted at once. No res_valid is produced and rr_ptr returns to 0.
- busy = (state != IDLE), driven from a register with no combinational path from req.
- gnt is never multi-hot. res_valid is never high in two consecutive cycles.

Test Plan:
1. Reset and single request: release reset; assert req=0001 with op_sel0=01, a0=0xA0, b0=0x0C -> gnt=0001 for exactly 1 cycle, then res_valid=1 for 1 cycle with res_data=0xAC, res_id=0; busy=1 for those 2 cycles.
2. All opcodes on requester 2, a=0xF0, b=0x3C -> AND=0x30, OR=0xFC, XOR=0xCC, NOR=0x03; each result carries res_id=2.
3. Fairness: hold req=1111 continuously with each requester on its own operands -> grant order 0,1,2,3,0,1; each res_id matches the preceding grant; exactly 3-cycle spacing between res_valid pulses.
4. Wrap and skip: after requester 3 is served, assert req=0110 -> requester 1 wins, then requester 2; requester 0 is never granted.
5. Operand change after grant: change a1 from 0x11 to 0xFF while gnt[1]=1 with op OR, b1=0x00 -> res_data=0x11.
6. Reset mid-operation: pull rst_n low during EXEC -> gnt, busy and res_valid all go to 0 immediately; no result strobe after release; the next request with req=1111 grants requester 0 first.
